// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/writeback
// and decodes datapath strobes from the registered state.
module multicycle_control #(
    parameter int unsigned ALUOP_W  = 4,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pcwrite,
    output logic [1:0]          pcsource,
    output logic                iord,
    output logic                irwrite,
    output logic                memread,
    output logic                memwrite,
    output logic                memtoreg,
    output logic [1:0]          regdst,
    output logic                regwrite,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic                zeroext,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                illegal,
    output logic                bus_error,
    output logic [RETIRE_W-1:0] retired
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_JR     = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(8);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_REXEC,
        S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                trap_bus_q, trap_bus_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                r_legal_c;
    logic [ALUOP_W-1:0]  r_aluop_c;
    logic                wait_done_c;

    assign wait_done_c = (wait_q == WAIT_W'(MAX_WAIT));
    assign retired     = retired_q;

    // R-type func field decode: legality and ALU operation
    always_comb begin
        r_legal_c = 1'b1;
        r_aluop_c = ALU_ADD;
        case (func)
            6'b100000: r_aluop_c = ALU_ADD;
            6'b100010: r_aluop_c = ALU_SUB;
            6'b100100: r_aluop_c = ALU_AND;
            6'b100101: r_aluop_c = ALU_OR;
            6'b100110: r_aluop_c = ALU_XOR;
            6'b101010: r_aluop_c = ALU_SLT;
            6'b101011: r_aluop_c = ALU_SLTU;
            default:   r_legal_c = 1'b0;
        endcase
    end

    // Next-state, wait counter, retire counter and control strobes
    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        trap_bus_d = trap_bus_q;
        retired_d  = retired_q;
        pcwrite    = 1'b0;
        pcsource   = 2'b00;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 2'b00;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        zeroext    = 1'b0;
        aluop      = ALU_ADD;
        illegal    = 1'b0;
        bus_error  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_done_c) begin
                    trap_bus_d = 1'b1;
                    state_d    = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                trap_bus_d = 1'b0;
                case (opcode)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (func == F_JR)   state_d = S_JR;
                        else if (r_legal_c) state_d = S_REXEC;
                        else                state_d = S_TRAP;
                    end
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_JAL:                 state_d = S_JAL;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_done_c) begin
                    trap_bus_d = 1'b1;
                    state_d    = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_MEMWB: begin
                regwrite  = 1'b1;
                memtoreg  = 1'b1;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    retired_d = retired_q + RETIRE_W'(1);
                    state_d   = S_FETCH;
                end else if (wait_done_c) begin
                    trap_bus_d = 1'b1;
                    state_d    = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_REXEC: begin
                alusrca = 1'b1;
                aluop   = r_aluop_c;
                state_d = S_RWB;
            end
            S_RWB: begin
                regwrite  = 1'b1;
                regdst    = 2'b01;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (opcode)
                    OP_ORI: begin
                        aluop   = ALU_OR;
                        zeroext = 1'b1;
                    end
                    OP_LUI:  aluop = ALU_LUI;
                    default: aluop = ALU_ADD;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                regwrite  = 1'b1;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca   = 1'b1;
                aluop     = ALU_SUB;
                pcsource  = 2'b01;
                pcwrite   = (opcode == OP_BNE) ? ~zero : zero;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pcwrite   = 1'b1;
                pcsource  = 2'b10;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_JAL: begin
                pcwrite   = 1'b1;
                pcsource  = 2'b10;
                regwrite  = 1'b1;
                regdst    = 2'b10;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_JR: begin
                pcwrite   = 1'b1;
                pcsource  = 2'b11;
                retired_d = retired_q + RETIRE_W'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                illegal   = ~trap_bus_q;
                bus_error = trap_bus_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, wait counter, trap cause and retire counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            trap_bus_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            trap_bus_q <= trap_bus_d;
            retired_q  <= retired_d;
        end
    end

endmodule
